// File: rtl/mdu_issue_ctrl.sv
// MDU issue/writeback scheduler: reserves two consecutive writeback slots per HI/LO pair.
// Optional macro MDU_DIV_PIPELINED_EN treats the divider as fully pipelined.
module mdu_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 20,
  parameter int ID_W    = 6,
  parameter int PREG_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_div,
  input  logic              in_unsigned,
  input  logic [ID_W-1:0]   in_hi_id,
  input  logic [ID_W-1:0]   in_lo_id,
  input  logic [PREG_W-1:0] in_hi_dst,
  input  logic [PREG_W-1:0] in_lo_dst,
  output logic              issue_mul,
  output logic              issue_div,
  output logic              issue_unsigned,
  output logic              wb_valid,
  output logic              wb_is_hi,
  output logic              wb_is_div,
  output logic [PREG_W-1:0] wb_dst,
  output logic [ID_W-1:0]   wb_rob_id,
  output logic              busy
);

  localparam int DEPTH = DIV_LAT + 2;
  localparam int CNT_W = $clog2(DIV_LAT + 1);

  typedef struct packed {
    logic              vld;
    logic              isHi;
    logic              isDiv;
    logic [PREG_W-1:0] dst;
    logic [ID_W-1:0]   id;
  } resEntry_t;

  resEntry_t res [DEPTH];
  resEntry_t hiEnt;
  resEntry_t loEnt;
  logic      mulFree;
  logic      divFree;
  logic      divAvail;
  logic      accept;

  // Slot check uses pre-shift indices: res[L] and res[L+1] become res[L-1] and res[L] next cycle.
  assign mulFree = !res[MUL_LAT].vld && !res[MUL_LAT+1].vld;
  assign divFree = !res[DIV_LAT].vld && !res[DIV_LAT+1].vld && divAvail;

  assign in_ready       = !rst && !flush && (in_is_div ? divFree : mulFree);
  assign accept         = in_valid && in_ready;
  assign issue_mul      = accept && !in_is_div;
  assign issue_div      = accept && in_is_div;
  assign issue_unsigned = accept && in_unsigned;

  always_comb begin
    hiEnt       = '0;
    hiEnt.vld   = 1'b1;
    hiEnt.isHi  = 1'b1;
    hiEnt.isDiv = in_is_div;
    hiEnt.dst   = in_hi_dst;
    hiEnt.id    = in_hi_id;
    loEnt       = '0;
    loEnt.vld   = 1'b1;
    loEnt.isHi  = 1'b0;
    loEnt.isDiv = in_is_div;
    loEnt.dst   = in_lo_dst;
    loEnt.id    = in_lo_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) res[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) res[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) res[i] <= res[i+1];
      res[DEPTH-1] <= '0;
      if (issue_mul) begin
        res[MUL_LAT-1] <= hiEnt;
        res[MUL_LAT]   <= loEnt;
      end
      if (issue_div) begin
        res[DIV_LAT-1] <= hiEnt;
        res[DIV_LAT]   <= loEnt;
      end
    end
  end

`ifdef MDU_DIV_PIPELINED_EN
  assign divAvail = 1'b1;
`else
  logic [CNT_W-1:0] divCnt;

  // Loaded with DIV_LAT-1 so the next divide can issue in the cycle the previous HI writes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt <= '0;
    end else if (flush) begin
      divCnt <= '0;
    end else if (issue_div) begin
      divCnt <= CNT_W'(DIV_LAT - 1);
    end else if (divCnt != '0) begin
      divCnt <= divCnt - CNT_W'(1);
    end
  end

  assign divAvail = (divCnt == '0);
`endif

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | res[i].vld;
  end

  assign wb_valid  = res[0].vld;
  assign wb_is_hi  = res[0].isHi;
  assign wb_is_div = res[0].isDiv;
  assign wb_dst    = res[0].dst;
  assign wb_rob_id = res[0].id;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: directed issue vectors, expected writebacks queued by cycle.
module tb_mdu_issue_ctrl;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 20;
  localparam int ID_W    = 6;
  localparam int PREG_W  = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_is_div = 1'b0;
  logic              in_unsigned = 1'b0;
  logic [ID_W-1:0]   in_hi_id = '0;
  logic [ID_W-1:0]   in_lo_id = '0;
  logic [PREG_W-1:0] in_hi_dst = '0;
  logic [PREG_W-1:0] in_lo_dst = '0;
  logic              issue_mul, issue_div, issue_unsigned;
  logic              wb_valid, wb_is_hi, wb_is_div;
  logic [PREG_W-1:0] wb_dst;
  logic [ID_W-1:0]   wb_rob_id;
  logic              busy;

  mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ID_W(ID_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_div(in_is_div), .in_unsigned(in_unsigned),
    .in_hi_id(in_hi_id), .in_lo_id(in_lo_id), .in_hi_dst(in_hi_dst), .in_lo_dst(in_lo_dst),
    .issue_mul(issue_mul), .issue_div(issue_div), .issue_unsigned(issue_unsigned),
    .wb_valid(wb_valid), .wb_is_hi(wb_is_hi), .wb_is_div(wb_is_div),
    .wb_dst(wb_dst), .wb_rob_id(wb_rob_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit isHi;
    bit isDiv;
    int dst;
    int id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  task automatic expWb(int c, bit isDiv, int hiDst, int loDst, int hiId, int loId);
    exp_t e;
    e.cyc = c;     e.isHi = 1'b1; e.isDiv = isDiv; e.dst = hiDst; e.id = hiId;
    sb.push_back(e);
    e.cyc = c + 1; e.isHi = 1'b0; e.isDiv = isDiv; e.dst = loDst; e.id = loId;
    sb.push_back(e);
  endtask

  task automatic drive(bit v, bit d, bit u, int hd, int ld, int hi, int li);
    in_valid    = v;
    in_is_div   = d;
    in_unsigned = u;
    in_hi_dst   = PREG_W'(hd);
    in_lo_dst   = PREG_W'(ld);
    in_hi_id    = ID_W'(hi);
    in_lo_id    = ID_W'(li);
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) nextCyc();
  endtask

  // Writeback monitor: every wb_valid must match the head of the scoreboard in the expected cycle.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL wb_missing cyc=%0d got=none want_cyc=%0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (wb_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL wb_unexpected cyc=%0d got=dst%0d/id%0d want=no_wb", cyc, wb_dst, wb_rob_id);
        end else if (sb[0].cyc != cyc) begin
          bad++;
          $display("FAIL wb_early cyc=%0d got=wb want_cyc=%0d", cyc, sb[0].cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (wb_is_hi !== e.isHi || wb_is_div !== e.isDiv ||
              int'(wb_dst) != e.dst || int'(wb_rob_id) != e.id) begin
            bad++;
            $display("FAIL wb_fields cyc=%0d got=hi%0b div%0b dst%0d id%0d want=hi%0b div%0b dst%0d id%0d",
                     cyc, wb_is_hi, wb_is_div, wb_dst, wb_rob_id, e.isHi, e.isDiv, e.dst, e.id);
          end
        end
      end
    end
  end

  initial begin
    int b;
    int lastK;

    // reset state, with a request offered during reset
    drive(1, 0, 0, 1, 2, 3, 4);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_issue_mul", issue_mul, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_wb_rob_id", wb_rob_id, 0);
    nextCyc();
    rst = 1'b0;
    idle(3);

    // single multiply
    nextCyc(); b = cyc;
    drive(1, 0, 0, 12, 13, 4, 5);
    expWb(b + 5, 0, 12, 13, 4, 5);
    @(negedge clk);
    chk("A_ready", in_ready, 1);
    chk("A_issue_mul", issue_mul, 1);
    chk("A_issue_div", issue_div, 0);
    chk("A_issue_uns", issue_unsigned, 0);
    nextCyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("A_busy", busy, 1);
    idle(10);

    // back-to-back multiplies: one every two cycles
    nextCyc(); b = cyc;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nextCyc();
      drive(1, 0, 0, 20 + 2*(k/2), 21 + 2*(k/2), 10 + 2*(k/2), 11 + 2*(k/2));
      @(negedge clk);
      chk("B_ready", in_ready, (k % 2 == 0) ? 1 : 0);
    end
    expWb(b + 5, 0, 20, 21, 10, 11);
    expWb(b + 7, 0, 22, 23, 12, 13);
    expWb(b + 9, 0, 24, 25, 14, 15);
    nextCyc();
    idle(12);

    // divide then a multiply whose slots overlap it
    nextCyc(); b = cyc;
    drive(1, 1, 1, 30, 31, 1, 2);
    expWb(b + 20, 1, 30, 31, 1, 2);
    @(negedge clk);
    chk("C_div_ready", in_ready, 1);
    chk("C_issue_div", issue_div, 1);
    chk("C_issue_mul", issue_mul, 0);
    chk("C_issue_uns", issue_unsigned, 1);
    nextCyc();
    idle(12);
    for (int k = 14; k <= 17; k++) begin
      nextCyc();
      drive(1, 0, 0, 40, 41, 6, 7);
      @(negedge clk);
      chk("C_mul_ready", in_ready, (k == 17) ? 1 : 0);
    end
    expWb(b + 22, 0, 40, 41, 6, 7);
    nextCyc();
    idle(30);

    // two divides back to back
    nextCyc(); b = cyc;
    drive(1, 1, 0, 50, 51, 8, 9);
    expWb(b + 20, 1, 50, 51, 8, 9);
    @(negedge clk);
    chk("D_div1_ready", in_ready, 1);
    nextCyc();
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef MDU_DIV_PIPELINED_EN
    lastK = 2;
`else
    lastK = 20;
`endif
    for (int k = 2; k <= lastK; k++) begin
      nextCyc();
      drive(1, 1, 0, 52, 53, 10, 11);
      @(negedge clk);
      chk("D_div2_ready", in_ready, (k == lastK) ? 1 : 0);
    end
    expWb(b + lastK + 20, 1, 52, 53, 10, 11);
    nextCyc();
    idle(45);

    // flush kills an in-flight multiply and rejects a same-cycle request
    nextCyc(); b = cyc;
    drive(1, 0, 0, 60, 61, 12, 13);
    @(negedge clk);
    chk("E_ready", in_ready, 1);
    nextCyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("E_busy_before", busy, 1);
    nextCyc();
    nextCyc();
    flush = 1'b1;
    drive(1, 0, 0, 62, 63, 14, 15);
    @(negedge clk);
    chk("E_flush_ready", in_ready, 0);
    chk("E_flush_issue", issue_mul, 0);
    nextCyc();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("E_busy_after", busy, 0);
    idle(10);

    // asynchronous reset while a divide is pending and a multiply is issuing
    nextCyc(); b = cyc;
    drive(1, 1, 0, 70, 71, 16, 17);
    @(negedge clk);
    chk("F_div_ready", in_ready, 1);
    nextCyc();
    idle(5);
    nextCyc();
    drive(1, 0, 0, 72, 73, 18, 19);
    @(negedge clk);
    chk("F_busy_pre", busy, 1);
    chk("F_issue_mul_pre", issue_mul, 1);
    #1 rst = 1'b1;
    #1;
    chk("F_wb_valid", wb_valid, 0);
    chk("F_busy", busy, 0);
    chk("F_issue_mul", issue_mul, 0);
    chk("F_in_ready", in_ready, 0);
    nextCyc();
    idle(2);
    rst = 1'b0;
    idle(30);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
